// File: rtl/stream_upsizer.sv
// Valid/ready width converter: packs RATIO narrow beats into one wide beat (beat 0 in lane 0).
// A packet ending early (s_last) flushes a partial wide beat with a lane-keep mask.
module stream_upsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO,
    parameter int CNT_W     = $clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_vld,
    output logic                 s_rdy,
    input  logic [IN_WIDTH-1:0]  s_pld,
    input  logic                 s_last,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic [OUT_WIDTH-1:0] m_pld,
    output logic [RATIO-1:0]     m_keep,
    output logic                 m_last
);

    logic [CNT_W-1:0]     cnt_r;
    logic [OUT_WIDTH-1:0] acc_r;
    logic [RATIO-1:0]     acc_keep_r;
    logic                 m_vld_r;
    logic [OUT_WIDTH-1:0] m_pld_r;
    logic [RATIO-1:0]     m_keep_r;
    logic                 m_last_r;

    logic                 s_rdy_s;
    logic                 accept_s;
    logic                 complete_s;
    logic [OUT_WIDTH-1:0] merged_pld_s;
    logic [RATIO-1:0]     merged_keep_s;

    // Handshake decode and accumulator-with-current-beat merge
    always_comb begin
        s_rdy_s       = !m_vld_r || m_rdy;
        accept_s      = s_vld && s_rdy_s;
        merged_pld_s  = acc_r;
        merged_pld_s[cnt_r*IN_WIDTH +: IN_WIDTH] = s_pld;
        merged_keep_s = acc_keep_r | (RATIO'(1) << cnt_r);
        if (accept_s) begin
            complete_s = (cnt_r == CNT_W'(RATIO - 1)) || s_last;
        end else begin
            complete_s = 1'b0;
        end
    end

    // Lane accumulator and lane counter; cleared whenever a wide beat is emitted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= '0;
            acc_r      <= '0;
            acc_keep_r <= '0;
        end else if (complete_s) begin
            cnt_r      <= '0;
            acc_r      <= '0;
            acc_keep_r <= '0;
        end else if (accept_s) begin
            cnt_r      <= cnt_r + CNT_W'(1);
            acc_r      <= merged_pld_s;
            acc_keep_r <= merged_keep_s;
        end
    end

    // Output register: a completing beat reloads it even while the old beat drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld_r  <= 1'b0;
            m_pld_r  <= '0;
            m_keep_r <= '0;
            m_last_r <= 1'b0;
        end else if (complete_s) begin
            m_vld_r  <= 1'b1;
            m_pld_r  <= merged_pld_s;
            m_keep_r <= merged_keep_s;
            m_last_r <= s_last;
        end else if (m_vld_r && m_rdy) begin
            m_vld_r  <= 1'b0;
        end
    end

    assign s_rdy  = s_rdy_s;
    assign m_vld  = m_vld_r;
    assign m_pld  = m_pld_r;
    assign m_keep = m_keep_r;
    assign m_last = m_last_r;

endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer: a directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based packing model.
module tb_stream_upsizer;

    localparam int IW = 32;
    localparam int R  = 4;
    localparam int OW = IW * R;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_vld;
    logic          s_rdy;
    logic [IW-1:0] s_pld;
    logic          s_last;
    logic          m_vld;
    logic          m_rdy;
    logic [OW-1:0] m_pld;
    logic [R-1:0]  m_keep;
    logic          m_last;

    stream_upsizer #(.IN_WIDTH(IW), .RATIO(R)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_vld(s_vld), .s_rdy(s_rdy), .s_pld(s_pld), .s_last(s_last),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_pld(m_pld), .m_keep(m_keep), .m_last(m_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: narrow beats waiting to be packed, plus the expected output register
    logic [IW-1:0] pend_q[$];
    logic          exp_full;
    logic [OW-1:0] exp_pld;
    logic [R-1:0]  exp_keep;
    logic          exp_last;

    typedef struct {
        logic          vld;
        logic [IW-1:0] pld;
        logic          last;
        logic          rdy;
        logic          e_srdy;
        logic          e_mvld;
        logic [OW-1:0] e_pld;
        logic [R-1:0]  e_keep;
        logic          e_last;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        exp_full = 1'b0;
        exp_pld  = '0;
        exp_keep = '0;
        exp_last = 1'b0;
    endtask

    task automatic drive(input logic vld, input logic [IW-1:0] pld, input logic last, input logic rdy);
        s_vld  = vld;
        s_pld  = pld;
        s_last = last;
        m_rdy  = rdy;
        #2;
    endtask

    // Compare against the model mid-cycle, advance the model, then move past the next edge
    task automatic model_step();
        logic          acc;
        logic [OW-1:0] w;
        logic [R-1:0]  k;
        check("s_rdy", OW'(s_rdy), OW'(!exp_full || m_rdy));
        check("m_vld", OW'(m_vld), OW'(exp_full));
        if (exp_full) begin
            check("m_pld", m_pld, exp_pld);
            check("m_keep", OW'(m_keep), OW'(exp_keep));
            check("m_last", OW'(m_last), OW'(exp_last));
        end
        acc = s_vld && (!exp_full || m_rdy);
        if (exp_full && m_rdy) exp_full = 1'b0;
        if (acc) begin
            pend_q.push_back(s_pld);
            if (pend_q.size() == R || s_last) begin
                w = '0;
                k = '0;
                for (int i = 0; i < pend_q.size(); i++) begin
                    w[i*IW +: IW] = pend_q[i];
                    k[i] = 1'b1;
                end
                exp_pld  = w;
                exp_keep = k;
                exp_last = s_last;
                exp_full = 1'b1;
                pend_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic vld, input logic [IW-1:0] pld, input logic last, input logic rdy);
        drive(vld, pld, last, rdy);
        model_step();
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 4'h0, 1'b0};
        tbl[1] = '{1'b1, 32'h22222222, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 4'h0, 1'b0};
        tbl[2] = '{1'b1, 32'h33333333, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 4'h0, 1'b0};
        tbl[3] = '{1'b1, 32'h44444444, 1'b1, 1'b1, 1'b1, 1'b0, 128'h0, 4'h0, 1'b0};
        tbl[4] = '{1'b1, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b1, 1'b1,
                   128'h44444444_33333333_22222222_11111111, 4'hF, 1'b1};
        tbl[5] = '{1'b1, 32'hBBBBBBBB, 1'b1, 1'b1, 1'b1, 1'b0, 128'h0, 4'h0, 1'b0};
        tbl[6] = '{1'b1, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b1, 1'b1,
                   128'h00000000_00000000_BBBBBBBB_AAAAAAAA, 4'h3, 1'b1};
        tbl[7] = '{1'b0, 32'hCCCCCCCC, 1'b1, 1'b0, 1'b0, 1'b1,
                   128'h00000000_00000000_00000000_5A5A5A5A, 4'h1, 1'b1};
        tbl[8] = '{1'b0, 32'hCCCCCCCC, 1'b0, 1'b1, 1'b1, 1'b1,
                   128'h00000000_00000000_00000000_5A5A5A5A, 4'h1, 1'b1};
        tbl[9] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 4'h0, 1'b0};

        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check("rst_m_vld", OW'(m_vld), OW'(0));
        check("rst_m_pld", m_pld, OW'(0));
        check("rst_m_keep", OW'(m_keep), OW'(0));
        check("rst_m_last", OW'(m_last), OW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: full word, partial packet, single-beat packet, short stall
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].vld, tbl[i].pld, tbl[i].last, tbl[i].rdy);
            check($sformatf("tbl%0d_s_rdy", i), OW'(s_rdy), OW'(tbl[i].e_srdy));
            check($sformatf("tbl%0d_m_vld", i), OW'(m_vld), OW'(tbl[i].e_mvld));
            if (tbl[i].e_mvld) begin
                check($sformatf("tbl%0d_m_pld", i), m_pld, tbl[i].e_pld);
                check($sformatf("tbl%0d_m_keep", i), OW'(m_keep), OW'(tbl[i].e_keep));
                check($sformatf("tbl%0d_m_last", i), OW'(m_last), OW'(tbl[i].e_last));
            end
            model_step();
        end

        // Backpressure: produce one wide beat, stall with s_vld held high, then release
        for (int i = 0; i < R; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
            check("stall_s_rdy", OW'(s_rdy), OW'(0));
            model_step();
        end
        drive(1'b1, 32'hC0, 1'b0, 1'b1);
        check("release_s_rdy", OW'(s_rdy), OW'(1));
        model_step();
        for (int i = 1; i < R; i++) step(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Streaming: eight back-to-back beats, no bubbles
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b1);
            check("stream_s_rdy", OW'(s_rdy), OW'(1));
            model_step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check("stream_m_pld", m_pld, 128'h00000008_00000007_00000006_00000005);
        check("stream_m_keep", OW'(m_keep), OW'(4'hF));
        check("stream_m_last", OW'(m_last), OW'(0));
        model_step();

        // Reset mid-packet: the partial lanes must not leak into the next wide beat
        step(1'b1, 32'h99999999, 1'b0, 1'b1);
        step(1'b1, 32'h88888888, 1'b0, 1'b1);
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check("mid_rst_m_vld", OW'(m_vld), OW'(0));
        check("mid_rst_m_pld", m_pld, OW'(0));
        check("mid_rst_m_keep", OW'(m_keep), OW'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < R; i++) step(1'b1, {4{8'hD0 + 8'(i)}}, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check("post_rst_m_pld", m_pld, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
        check("post_rst_m_keep", OW'(m_keep), OW'(4'hF));
        model_step();

        // Random traffic against the packing model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Valid/ready width converter. Packs RATIO consecutive narrow beats into one wide beat, with beat 0 in the least-significant lane.
- Sits directly upstream of a reg_slice on wide datapaths. Its registered m_* side feeds the slice's s_* side.
- s_last ends a packet early. A partial wide beat is flushed with a lane-keep mask.

Parameters:
IN_WIDTH, 32, width of one narrow input beat
RATIO, 4, narrow beats per wide beat; power of two, >= 2
OUT_WIDTH, IN_WIDTH*RATIO, derived, must not be overridden
CNT_W, $clog2(RATIO), derived lane-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_vld  in  1  input beat valid
s_rdy  out  1  input beat ready
s_pld  in  IN_WIDTH  input beat payload
s_last  in  1  last beat of packet
m_vld  out  1  wide beat valid
m_rdy  in  1  wide beat ready
m_pld  out  OUT_WIDTH  wide payload; lane i = bits [i*IN_WIDTH +: IN_WIDTH]
m_keep  out  RATIO  lane i holds valid data
m_last  out  1  wide beat closes a packet

Behaviour:
- Single clock, clk. Asynchronous active-low reset rst_n.
- Reset values: m_vld=0, m_pld=0, m_keep=0, m_last=0. Lane counter cnt=0. Accumulator and its keep bits = 0.
- Reset mid-packet discards partial data and any pending output. The first beat after reset goes to lane 0.
- s_rdy = !m_vld || m_rdy. There is no combinational path from s_vld, s_pld or s_last to s_rdy.
- Accept: s_vld && s_rdy. An accepted beat is written to lane cnt of the accumulator, and that lane's keep bit is set.
- Completing beat: an accept with cnt==RATIO-1 or s_last==1.
  - On the next edge: m_pld <= accumulator with the current beat merged into lane cnt. m_keep <= lanes filled, including the current one. m_last <= s_last. m_vld <= 1.
  - Accumulator and keep are cleared in the same edge. cnt <= 0.
- Non-completing accept: cnt <= cnt+1. The output register is untouched.
- Latency: completing beat accepted in cycle t gives m_vld=1 in cycle t+1.
- Throughput: 1 wide beat per RATIO input beats while m_rdy=1. No bubbles.
- Output handshake: m_vld && m_rdy with no completing beat in the same cycle gives m_vld <= 0. m_pld, m_keep and m_last keep their values; contents are don't-care while m_vld=0.
- Simultaneous drain and completing beat in the same cycle: the output register reloads and m_vld stays 1.
- Backpressure: while m_vld=1 and m_rdy=0, s_rdy=0 and the accumulator holds. m_pld, m_keep and m_last stay stable until accepted.
- Unfilled lanes of a partial beat are 0. Their m_keep bits are 0.
- Full word without s_last: m_keep all ones, m_last=0.
- s_last on lane RATIO-1: m_keep all ones, m_last=1.
- cnt wraps RATIO-1 -> 0 only via completion. There is no overflow state.
- s_pld and s_last are ignored when the beat is not accepted.

Test Plan:
1. Full word. IN_WIDTH=32, RATIO=4, m_rdy=1. Send beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (s_last on the 4th) -> one cycle after the 4th accept: m_pld=0x44444444_33333333_22222222_11111111, m_keep=4'hF, m_last=1.
2. Partial packet. Send 0xAAAAAAAA, then 0xBBBBBBBB with s_last -> m_pld=0x00000000_00000000_BBBBBBBB_AAAAAAAA, m_keep=4'h3, m_last=1. The next beat 0xCC.. lands in lane 0.
3. Single-beat packet. Send 0x5A5A5A5A with s_last at cnt=0 -> m_keep=4'h1, m_pld lane0=0x5A5A5A5A, other lanes 0.
4. Backpressure. Hold m_rdy=0 after one wide beat is produced, with s_vld=1 -> s_rdy=0 for the whole stall; m_pld and m_keep stable. Release m_rdy=1 -> s_rdy=1 the same cycle; no beat lost or duplicated.
5. Streaming. 8 continuous beats 0x1..0x8, no s_last, m_rdy=1 -> s_rdy=1 every cycle. Two wide beats 0x4_3_2_1 and 0x8_7_6_5 (per lane), m_keep=4'hF, m_last=0.
6. Reset mid-packet. Accept 2 beats, assert rst_n=0 for 1 cycle -> all outputs 0. Then 4 beats D0..D3 -> a single wide beat D3_D2_D1_D0 with no stale lanes.
